// File: rtl/uart_test_services.sv
// Bring-up services: fake ADC sawtooth, UART byte echo and UART counting responder.
// Both UART functions share one uart_tx request port, and replay wins when both are active.
module uart_test_services #(
   parameter logic [7:0] ADC_STEP   = 8'd1,
   parameter logic [7:0] REPLAY_END = 8'h0D
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       adc_tick,
   output logic [7:0] adc_data,
   input  logic       replay_activate,
   output logic       replay_done,
   input  logic       cnt_activate,
   output logic       cnt_done,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   input  logic       tx_active,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data
);

   // state       | meaning
   // *_IDLE      | function not activated, drives nothing
   // RPL_WAIT_RX | waiting for a fresh rx byte to echo
   // CNT_WAIT_N  | waiting for the count byte N
   // *_SEND      | byte ready, start uart_tx once it is idle
   // *_WAIT_TX   | start issued, waiting for tx_done
   // *_DONE      | session complete, done held until activate falls
   typedef enum logic [2:0] {
      RPL_IDLE, RPL_WAIT_RX, RPL_SEND, RPL_WAIT_TX, RPL_DONE
   } rpl_state_t;

   typedef enum logic [2:0] {
      CNT_IDLE, CNT_WAIT_N, CNT_SEND, CNT_WAIT_TX, CNT_DONE
   } cnt_state_t;

   logic [7:0] adc_d, adc_q;
   logic       rx_ready_d, rx_ready_q;
   logic       last_rpl_d, last_rpl_q;
   logic       new_byte;
   logic       cnt_en;

   rpl_state_t rpl_state_q;
   logic [7:0] rpl_byte_q, rpl_tx_q;
   logic       rpl_start_q, rpl_done_q;

   cnt_state_t cnt_state_q;
   logic [7:0] cnt_n_q, cnt_k_q, cnt_tx_q;
   logic       cnt_start_q, cnt_done_q;

   assign new_byte = rx_ready & ~rx_ready_q;
   assign cnt_en   = cnt_activate & ~replay_activate;

   // last_rpl tracks which function issued the most recent start so tx_data
   // stays on that byte until the next start.
   always_comb begin
      adc_d      = adc_q;
      rx_ready_d = rx_ready;
      last_rpl_d = last_rpl_q;
      if (adc_tick) begin
         adc_d = adc_q + ADC_STEP;
      end
      if (rpl_start_q) begin
         last_rpl_d = 1'b1;
      end else if (cnt_start_q) begin
         last_rpl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adc_q      <= '0;
         rx_ready_q <= 1'b0;
         last_rpl_q <= 1'b0;
      end else begin
         adc_q      <= adc_d;
         rx_ready_q <= rx_ready_d;
         last_rpl_q <= last_rpl_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rpl_state_q <= RPL_IDLE;
         rpl_byte_q  <= '0;
         rpl_tx_q    <= '0;
         rpl_start_q <= 1'b0;
         rpl_done_q  <= 1'b0;
      end else begin
         rpl_start_q <= 1'b0;
         if (!replay_activate) begin
            rpl_state_q <= RPL_IDLE;
            rpl_done_q  <= 1'b0;
         end else begin
            case (rpl_state_q)
               RPL_IDLE: rpl_state_q <= RPL_WAIT_RX;
               RPL_WAIT_RX: begin
                  if (new_byte) begin
                     rpl_byte_q  <= rx_data;
                     rpl_state_q <= RPL_SEND;
                  end
               end
               RPL_SEND: begin
                  if (!tx_active) begin
                     rpl_start_q <= 1'b1;
                     rpl_tx_q    <= rpl_byte_q;
                     rpl_state_q <= RPL_WAIT_TX;
                  end
               end
               RPL_WAIT_TX: begin
                  if (tx_done) begin
                     if (rpl_byte_q == REPLAY_END) begin
                        rpl_state_q <= RPL_DONE;
                        rpl_done_q  <= 1'b1;
                     end else begin
                        rpl_state_q <= RPL_WAIT_RX;
                     end
                  end
               end
               RPL_DONE: rpl_done_q <= 1'b1;
               default:  rpl_state_q <= RPL_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_state_q <= CNT_IDLE;
         cnt_n_q     <= '0;
         cnt_k_q     <= '0;
         cnt_tx_q    <= '0;
         cnt_start_q <= 1'b0;
         cnt_done_q  <= 1'b0;
      end else begin
         cnt_start_q <= 1'b0;
         if (!cnt_en) begin
            cnt_state_q <= CNT_IDLE;
            cnt_done_q  <= 1'b0;
         end else begin
            case (cnt_state_q)
               CNT_IDLE: cnt_state_q <= CNT_WAIT_N;
               CNT_WAIT_N: begin
                  if (new_byte) begin
                     cnt_n_q <= rx_data;
                     cnt_k_q <= '0;
                     if (rx_data == 8'd0) begin
                        cnt_state_q <= CNT_DONE;
                        cnt_done_q  <= 1'b1;
                     end else begin
                        cnt_state_q <= CNT_SEND;
                     end
                  end
               end
               CNT_SEND: begin
                  if (!tx_active) begin
                     cnt_start_q <= 1'b1;
                     cnt_tx_q    <= cnt_k_q;
                     cnt_state_q <= CNT_WAIT_TX;
                  end
               end
               CNT_WAIT_TX: begin
                  if (tx_done) begin
                     cnt_k_q <= cnt_k_q + 8'd1;
                     if (cnt_k_q + 8'd1 == cnt_n_q) begin
                        cnt_state_q <= CNT_DONE;
                        cnt_done_q  <= 1'b1;
                     end else begin
                        cnt_state_q <= CNT_SEND;
                     end
                  end
               end
               CNT_DONE: cnt_done_q <= 1'b1;
               default:  cnt_state_q <= CNT_IDLE;
            endcase
         end
      end
   end

   assign adc_data    = adc_q;
   assign replay_done = rpl_done_q;
   assign cnt_done    = cnt_done_q;
   assign tx_start    = rpl_start_q | cnt_start_q;
   assign tx_data     = (rpl_start_q | (last_rpl_q & ~cnt_start_q)) ? rpl_tx_q : cnt_tx_q;

endmodule

// File: tb/tb_uart_test_services.sv
// Randomized directed bench for uart_test_services with a queue-based reference model
// of the expected UART byte stream and a simple uart_tx responder.
module tb_uart_test_services;

   logic       clk = 1'b0;
   logic       reset;
   logic       adc_tick;
   logic [7:0] adc_data;
   logic       replay_activate, replay_done;
   logic       cnt_activate, cnt_done;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       tx_active, tx_done, tx_start;
   logic [7:0] tx_data;
   logic       uart_busy, hold_busy;

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] tx_log[$];
   logic [7:0] exp_q[$];
   bit         outstanding;
   int         busy_cnt;
   int         adc_exp;
   int         snap;
   logic [7:0] b;

   assign tx_active = uart_busy | hold_busy;

   always #10 clk = ~clk;

   uart_test_services dut (
      .clk             (clk),
      .reset           (reset),
      .adc_tick        (adc_tick),
      .adc_data        (adc_data),
      .replay_activate (replay_activate),
      .replay_done     (replay_done),
      .cnt_activate    (cnt_activate),
      .cnt_done        (cnt_done),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .tx_active       (tx_active),
      .tx_done         (tx_done),
      .tx_start        (tx_start),
      .tx_data         (tx_data)
   );

   // uart_tx stand-in: logs every start, stays busy a random time, then pulses tx_done.
   initial begin
      uart_busy   = 1'b0;
      tx_done     = 1'b0;
      outstanding = 1'b0;
      busy_cnt    = 0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (tx_start === 1'b1) begin
            n_assert++;
            assert (outstanding === 1'b0) else begin
               n_fail++;
               $error("FAIL tx_double_start: observed outstanding=%0b expected 0", outstanding);
            end
            n_assert++;
            assert (tx_active === 1'b0) else begin
               n_fail++;
               $error("FAIL tx_start_while_active: observed tx_active=%0b expected 0", tx_active);
            end
            outstanding = 1'b1;
            tx_log.push_back(tx_data);
            uart_busy = 1'b1;
            busy_cnt  = $urandom_range(6, 2);
         end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               uart_busy   = 1'b0;
               tx_done     = 1'b1;
               outstanding = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] v);
      @(negedge clk);
      rx_data  = v;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_log(input int n, input string tag);
      int i;
      i = 0;
      while (tx_log.size() < n && i < 4000) begin
         @(negedge clk);
         i++;
      end
      chk(tag, 32'(tx_log.size()), 32'(n));
   endtask

   task automatic wait_quiet();
      int i;
      i = 0;
      while (outstanding && i < 200) begin
         @(negedge clk);
         i++;
      end
      cyc(2);
   endtask

   task automatic wait_done(input bit use_cnt, input string tag);
      int i;
      i = 0;
      while (((use_cnt ? cnt_done : replay_done) !== 1'b1) && i < 8000) begin
         @(negedge clk);
         i++;
      end
      chk(tag, 32'(use_cnt ? cnt_done : replay_done), 32'd1);
   endtask

   task automatic cmp_log(input string tag);
      chk({tag, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s[%0d]", tag, i),
             (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
      end
   endtask

   task automatic run_cnt(input logic [7:0] n);
      tx_log.delete();
      exp_q.delete();
      for (int k = 0; k < int'(n); k++) exp_q.push_back(8'(k));
      cnt_activate = 1'b1;
      cyc(2);
      send_rx(n);
      wait_done(1'b1, $sformatf("cnt_done_n%0d", n));
      wait_quiet();
      cmp_log($sformatf("cnt_tx_n%0d", n));
      cnt_activate = 1'b0;
      cyc(1);
      chk("cnt_done_clear", 32'(cnt_done), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      adc_tick        = 1'b0;
      replay_activate = 1'b0;
      cnt_activate    = 1'b0;
      rx_ready        = 1'b0;
      rx_data         = 8'h00;
      hold_busy       = 1'b0;
      adc_exp         = 0;
      cyc(3);
      chk("rst_adc",      32'(adc_data),    32'd0);
      chk("rst_tx_start", 32'(tx_start),    32'd0);
      chk("rst_tx_data",  32'(tx_data),     32'd0);
      chk("rst_rpl_done", 32'(replay_done), 32'd0);
      chk("rst_cnt_done", 32'(cnt_done),    32'd0);
      reset = 1'b0;
      cyc(2);

      // ADC sawtooth with random gaps between ticks
      for (int i = 1; i <= 300; i++) begin
         adc_tick = 1'b1;
         @(negedge clk);
         adc_tick = 1'b0;
         adc_exp  = (adc_exp + 1) % 256;
         @(negedge clk);
         if (i % 60 == 0 || i == 255 || i == 256)
            chk($sformatf("adc_after_%0d", i), 32'(adc_data), 32'(adc_exp));
         cyc($urandom_range(2, 0));
      end
      chk("adc_end_44", 32'(adc_data), 32'd44);

      // echo session: fixed bytes, random bytes, then the terminator
      tx_log.delete();
      exp_q.delete();
      replay_activate = 1'b1;
      cyc(2);
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      b = 8'h41;
         else if (i == 1) b = 8'h42;
         else if (i == 5) b = 8'h0D;
         else begin
            b = 8'($urandom_range(255, 0));
            if (b == 8'h0D) b = 8'h0E;
         end
         send_rx(b);
         exp_q.push_back(b);
         wait_log(exp_q.size(), $sformatf("echo_cnt_%0d", i));
         wait_quiet();
         if (b != 8'h0D) chk($sformatf("echo_not_done_%0d", i), 32'(replay_done), 32'd0);
      end
      wait_done(1'b0, "echo_done");
      cmp_log("echo_tx");
      replay_activate = 1'b0;
      cyc(1);
      chk("echo_done_clear", 32'(replay_done), 32'd0);

      run_cnt(8'd3);
      run_cnt(8'($urandom_range(20, 1)));
      run_cnt(8'd0);
      run_cnt(8'd255);

      // handshake: uart_tx held busy while an echo byte is pending
      tx_log.delete();
      replay_activate = 1'b1;
      cyc(2);
      hold_busy = 1'b1;
      send_rx(8'h5A);
      cyc(100);
      chk("hs_no_start", 32'(tx_log.size()), 32'd0);
      hold_busy = 1'b0;
      wait_log(1, "hs_released");
      wait_quiet();
      chk("hs_byte", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF_FFFF, 32'h5A);
      replay_activate = 1'b0;
      cyc(2);

      // stale rx_ready at activation must not be echoed
      tx_log.delete();
      rx_data  = 8'h55;
      rx_ready = 1'b1;
      cyc(3);
      replay_activate = 1'b1;
      cyc(10);
      chk("stale_ignored", 32'(tx_log.size()), 32'd0);
      rx_ready = 1'b0;
      cyc(1);
      send_rx(8'h66);
      wait_log(1, "stale_fresh_cnt");
      wait_quiet();
      chk("stale_fresh_byte", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF_FFFF, 32'h66);
      replay_activate = 1'b0;
      cyc(2);

      // both active: only the echo reaches uart_tx
      tx_log.delete();
      replay_activate = 1'b1;
      cnt_activate    = 1'b1;
      cyc(2);
      send_rx(8'h07);
      wait_log(1, "prio_cnt");
      wait_quiet();
      cyc(10);
      chk("prio_only_one", 32'(tx_log.size()), 32'd1);
      chk("prio_byte", (tx_log.size() > 0) ? 32'(tx_log[0]) : 32'hFFFF_FFFF, 32'h07);
      send_rx(8'h0D);
      wait_done(1'b0, "prio_rpl_done");
      chk("prio_cnt_done", 32'(cnt_done), 32'd0);
      replay_activate = 1'b0;
      cnt_activate    = 1'b0;
      cyc(2);
      wait_quiet();

      // deactivate mid-count
      tx_log.delete();
      cnt_activate = 1'b1;
      cyc(2);
      send_rx(8'd10);
      wait_log(3, "abort_progress");
      cnt_activate = 1'b0;
      cyc(1);
      chk("abort_tx_start", 32'(tx_start), 32'd0);
      chk("abort_cnt_done", 32'(cnt_done), 32'd0);
      wait_quiet();
      snap = tx_log.size();
      cyc(30);
      chk("abort_no_resend", 32'(tx_log.size()), 32'(snap));

      // reset mid-count
      tx_log.delete();
      cnt_activate = 1'b1;
      cyc(2);
      send_rx(8'd10);
      wait_log(2, "rstmid_progress");
      reset = 1'b1;
      cyc(1);
      chk("rstmid_tx_start", 32'(tx_start),    32'd0);
      chk("rstmid_tx_data",  32'(tx_data),     32'd0);
      chk("rstmid_adc",      32'(adc_data),    32'd0);
      chk("rstmid_cnt_done", 32'(cnt_done),    32'd0);
      chk("rstmid_rpl_done", 32'(replay_done), 32'd0);
      cnt_activate = 1'b0;
      reset        = 1'b0;
      adc_exp      = 0;
      wait_quiet();

      // a few more random ticks after reset
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            adc_tick = 1'b1;
            adc_exp  = (adc_exp + 1) % 256;
         end
         @(negedge clk);
         adc_tick = 1'b0;
      end
      cyc(1);
      chk("adc_post_reset", 32'(adc_data), 32'(adc_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
